step_counter_checker: RTL and testbench
=======================================

// Module: step_counter_checker
// PURPOSE
//  Downstream monitor for the stepped up-counter (INIT load on its sync reset, +STEP per enabled clock).
//  Samples the counter output every clock and predicts the next value from the counter's own reset/enable.
//  Acquires lock, then reports mismatches, wrap-arounds and a saturating error count to the test/status logic.
//  Sits beside the counter on the same clock; taps its reset, enable and count output.
// PARAMETERS
//  WIDTH   4  width of count_in / expected
//  STEP    2  increment applied per enabled clock (modulo 2**WIDTH)
//  INIT    1  value loaded by the counter's sync reset
//  LOCK_N  4  consecutive matching samples needed to reach LOCKED (1..15)
//  ERR_W   8  width of err_count and wrap_count
// PORTS
//  clock        in   1      single clock, rising edge
//  reset        in   1      asynchronous, active-low reset of this block
//  up_reset     in   1      counter's sync reset (active-high), as driven into the counter
//  up_enable    in   1      counter's enable, as driven into the counter
//  count_in     in   WIDTH  counter output
//  clear        in   1      sync: clear err_count/wrap_count, leave FAULT
//  locked       out  1      1 while state == LOCKED
//  error_pulse  out  1      1-cycle pulse on a mismatch in LOCKED
//  wrap_pulse   out  1      1-cycle pulse when a checked increment wraps past 2**WIDTH-1
//  expected     out  WIDTH  predicted value for the current count_in
//  err_count    out  ERR_W  mismatch count, saturating at all-ones
//  wrap_count   out  ERR_W  wrap count, saturating at all-ones
// BEHAVIOUR
//  - Reset (reset==0, async): state IDLE, hist_valid=0, match_cnt=0, locked=0, error_pulse=0,
//    wrap_pulse=0, expected=INIT, err_count=0, wrap_count=0. Release is sampled at next rising edge.
//  - Each edge registers d_rst<=up_reset, d_en<=up_enable, prev<=count_in, hist_valid<=1.
//  - Prediction (combinational from history): d_rst ? INIT : d_en ? prev+STEP (mod 2**WIDTH) : prev.
//    expected output is that prediction registered; match = (count_in == prediction) & hist_valid.
//  - count_in at edge k reflects the counter update from edge k-1; no same-edge comparison.
//  - FSM: IDLE -> ACQUIRE on first edge with hist_valid.
//    ACQUIRE: match -> match_cnt++; mismatch -> match_cnt=0; match_cnt reaching LOCK_N -> LOCKED.
//    LOCKED: mismatch -> FAULT, error_pulse=1, err_count++. match -> stay.
//    FAULT: d_rst with count_in==INIT, or clear -> ACQUIRE, match_cnt=0.
//  - Mismatches in IDLE/ACQUIRE/FAULT never raise error_pulse or bump err_count.
//  - Wrap: in LOCKED, d_en & !d_rst & carry out of prev+STEP & match -> wrap_pulse=1, wrap_count++.
//  - Counters saturate at 2**ERR_W-1; no rollover.
//  - clear same cycle as a mismatch: clear wins (counts go to 0, no pulse, state ACQUIRE).
//  - up_reset mid-run in LOCKED: expected value INIT, no error if counter obeys; lock kept.
//  - up_reset and up_enable both high: reset dominates (predict INIT), matching the counter.
//  - Pulses are registered, high exactly one cycle, default 0.
// TESTING
//  1 reset low 3 clk, release; up_reset 1 clk then up_enable=1: count 1,3,5,7,9 -> locked=1 after 4th match, no errors.
//  2 locked, run on: 13,15,1 -> wrap_pulse one cycle on 15->1, wrap_count=1, error_pulse=0.
//  3 locked, up_enable=0 for 3 clk at count 5 -> count stays 5, expected=5, no error, locked stays 1.
//  4 locked, force count_in=6 where 7 expected -> error_pulse 1 cycle, err_count=1, locked=0 (FAULT);
//    then clear -> err_count=0, ACQUIRE, relocks after 4 matches.
//  5 FAULT, pulse up_reset -> count_in=1 next edge -> ACQUIRE; up_reset+up_enable together -> expects 1, not +2.
//  6 locked, drop reset between edges -> all outputs to reset values immediately; ERR_W=2, 5 faults -> err_count=3.

Source files
------------

// File: rtl/step_counter_checker.sv
// Monitor for a stepped up-counter: predicts each sample from the counter's own reset/enable history,
// acquires lock, then flags mismatches and wrap-arounds with saturating counts.
module step_counter_checker #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned STEP   = 2,
    parameter int unsigned INIT   = 1,
    parameter int unsigned LOCK_N = 4,
    parameter int unsigned ERR_W  = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             up_reset,
    input  logic             up_enable,
    input  logic [WIDTH-1:0] count_in,
    input  logic             clear,
    output logic             locked,
    output logic             error_pulse,
    output logic             wrap_pulse,
    output logic [WIDTH-1:0] expected,
    output logic [ERR_W-1:0] err_count,
    output logic [ERR_W-1:0] wrap_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACQUIRE,
        S_LOCKED,
        S_FAULT
    } state_t;

    localparam logic [WIDTH-1:0] C_INIT      = WIDTH'(INIT);
    localparam logic [WIDTH-1:0] C_STEP      = WIDTH'(STEP);
    localparam logic [3:0]       C_LOCK_LAST = 4'(LOCK_N - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0]       r_match_cnt;
    logic [3:0]       w_match_cnt_nxt;
    logic             r_hist_valid;
    logic             r_d_rst;
    logic             r_d_en;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_pred;
    logic             w_match;
    logic             w_err_hit;
    logic             w_wrap_hit;

    // Extra MSB of the sum is the carry that marks a wrap past all-ones.
    assign w_sum   = {1'b0, r_prev} + {1'b0, C_STEP};
    assign w_pred  = r_d_rst ? C_INIT : (r_d_en ? w_sum[WIDTH-1:0] : r_prev);
    assign w_match = r_hist_valid && (count_in == w_pred);
    assign locked  = (r_state == S_LOCKED);

    always_comb begin
        w_state_nxt     = r_state;
        w_match_cnt_nxt = r_match_cnt;
        w_err_hit       = 1'b0;
        w_wrap_hit      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_hist_valid) begin
                    w_state_nxt     = S_ACQUIRE;
                    w_match_cnt_nxt = '0;
                end
            end
            S_ACQUIRE: begin
                if (!w_match) begin
                    w_match_cnt_nxt = '0;
                end else if (r_match_cnt == C_LOCK_LAST) begin
                    w_state_nxt     = S_LOCKED;
                    w_match_cnt_nxt = '0;
                end else begin
                    w_match_cnt_nxt = r_match_cnt + 4'd1;
                end
            end
            S_LOCKED: begin
                // A clear arriving with a mismatch suppresses the fault and restarts acquisition.
                if (!w_match) begin
                    w_state_nxt     = clear ? S_ACQUIRE : S_FAULT;
                    w_match_cnt_nxt = '0;
                    w_err_hit       = !clear;
                end else if (r_d_en && !r_d_rst && w_sum[WIDTH] && !clear) begin
                    w_wrap_hit = 1'b1;
                end
            end
            S_FAULT: begin
                if (clear || (r_d_rst && (count_in == C_INIT))) begin
                    w_state_nxt     = S_ACQUIRE;
                    w_match_cnt_nxt = '0;
                end
            end
            default: begin
                w_state_nxt     = S_IDLE;
                w_match_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_match_cnt  <= '0;
            r_hist_valid <= 1'b0;
            r_d_rst      <= 1'b0;
            r_d_en       <= 1'b0;
            r_prev       <= C_INIT;
            expected     <= C_INIT;
            error_pulse  <= 1'b0;
            wrap_pulse   <= 1'b0;
            err_count    <= '0;
            wrap_count   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_match_cnt  <= w_match_cnt_nxt;
            r_hist_valid <= 1'b1;
            r_d_rst      <= up_reset;
            r_d_en       <= up_enable;
            r_prev       <= count_in;
            expected     <= w_pred;
            error_pulse  <= w_err_hit;
            wrap_pulse   <= w_wrap_hit;
            if (clear) begin
                err_count  <= '0;
                wrap_count <= '0;
            end else begin
                if (w_err_hit && (err_count != '1)) begin
                    err_count <= err_count + 1'b1;
                end
                if (w_wrap_hit && (wrap_count != '1)) begin
                    wrap_count <= wrap_count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_step_counter_checker.sv
// Table-driven bench for step_counter_checker plus a narrow-counter instance for saturation and async reset.
module tb_step_counter_checker;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       up_reset = 1'b0;
    logic       up_enable = 1'b0;
    logic [3:0] count_in = '0;
    logic       clear = 1'b0;
    logic       locked, error_pulse, wrap_pulse;
    logic [3:0] expected;
    logic [7:0] err_count, wrap_count;

    logic       rst2 = 1'b0;
    logic       ur2 = 1'b0;
    logic       ue2 = 1'b0;
    logic [3:0] cin2 = '0;
    logic       locked2, ep2, wp2;
    logic [3:0] exp2;
    logic [1:0] ec2, wc2;
    logic [3:0] cnt2;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    typedef struct {
        logic       ur, ue;
        logic [3:0] cin;
        logic       clr;
        logic       lk, ep, wp;
        logic [3:0] ex;
        logic [7:0] ec, wc;
    } vec_t;

    typedef struct {
        logic       lk, ep, wp;
        logic [3:0] ex;
        logic [7:0] ec, wc;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    step_counter_checker #(.WIDTH(4), .STEP(2), .INIT(1), .LOCK_N(4), .ERR_W(8)) dut (
        .clock(clock), .reset(reset), .up_reset(up_reset), .up_enable(up_enable),
        .count_in(count_in), .clear(clear), .locked(locked), .error_pulse(error_pulse),
        .wrap_pulse(wrap_pulse), .expected(expected), .err_count(err_count), .wrap_count(wrap_count)
    );

    step_counter_checker #(.WIDTH(4), .STEP(2), .INIT(1), .LOCK_N(4), .ERR_W(2)) dut2 (
        .clock(clock), .reset(rst2), .up_reset(ur2), .up_enable(ue2),
        .count_in(cin2), .clear(1'b0), .locked(locked2), .error_pulse(ep2),
        .wrap_pulse(wp2), .expected(exp2), .err_count(ec2), .wrap_count(wc2)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", name, act, req);
    endtask

    task automatic v(input int ur, ue, cin, clr, lk, ep, wp, ex, ec, wc);
        vec_t t;
        t.ur = 1'(ur); t.ue = 1'(ue); t.cin = 4'(cin); t.clr = 1'(clr);
        t.lk = 1'(lk); t.ep = 1'(ep); t.wp = 1'(wp); t.ex = 4'(ex);
        t.ec = 8'(ec); t.wc = 8'(wc);
        vecs.push_back(t);
    endtask

    task automatic cyc2(input logic ur, input logic ue, input logic bad);
        ur2  = ur;
        ue2  = ue;
        cin2 = bad ? (cnt2 ^ 4'd1) : cnt2;
        @(posedge clock);
        cnt2 = ur ? 4'd1 : (ue ? cnt2 + 4'd2 : cnt2);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        exp_t e;
        int   want_ec;

        //    ur ue cin clr  lk ep wp ex ec wc
        v(1, 0,  0, 0,  0, 0, 0,  1, 0, 0);   // counter sync reset
        v(0, 1,  1, 0,  0, 0, 0,  1, 0, 0);
        v(0, 1,  3, 0,  0, 0, 0,  3, 0, 0);
        v(0, 1,  5, 0,  0, 0, 0,  5, 0, 0);
        v(0, 1,  7, 0,  0, 0, 0,  7, 0, 0);
        v(0, 1,  9, 0,  1, 0, 0,  9, 0, 0);   // 4th counted match -> LOCKED
        v(0, 1, 11, 0,  1, 0, 0, 11, 0, 0);
        v(0, 1, 13, 0,  1, 0, 0, 13, 0, 0);
        v(0, 1, 15, 0,  1, 0, 0, 15, 0, 0);
        v(0, 1,  1, 0,  1, 0, 1,  1, 0, 1);   // wrap 15 -> 1
        v(0, 1,  3, 0,  1, 0, 0,  3, 0, 1);
        v(0, 0,  5, 0,  1, 0, 0,  5, 0, 1);   // enable low 3 clocks
        v(0, 0,  5, 0,  1, 0, 0,  5, 0, 1);
        v(0, 0,  5, 0,  1, 0, 0,  5, 0, 1);
        v(0, 1,  5, 0,  1, 0, 0,  5, 0, 1);
        v(0, 1,  6, 0,  0, 1, 0,  7, 1, 1);   // corrupted sample -> FAULT
        v(0, 1,  9, 1,  0, 0, 0,  8, 0, 0);   // clear -> ACQUIRE, counts zeroed
        v(0, 1, 11, 0,  0, 0, 0, 11, 0, 0);
        v(0, 1, 13, 0,  0, 0, 0, 13, 0, 0);
        v(0, 1, 15, 0,  0, 0, 0, 15, 0, 0);
        v(0, 1,  1, 0,  1, 0, 0,  1, 0, 0);   // relock; wrap in ACQUIRE not counted
        v(0, 1,  3, 0,  1, 0, 0,  3, 0, 0);
        v(0, 1,  4, 0,  0, 1, 0,  5, 1, 0);   // FAULT
        v(1, 1,  7, 0,  0, 0, 0,  6, 1, 0);
        v(0, 1,  1, 0,  0, 0, 0,  1, 1, 0);   // reset seen with INIT -> ACQUIRE
        v(1, 1,  3, 0,  0, 0, 0,  3, 1, 0);   // reset+enable together
        v(0, 1,  1, 0,  0, 0, 0,  1, 1, 0);   // predicts INIT, not +STEP
        v(0, 1,  3, 0,  0, 0, 0,  3, 1, 0);
        v(0, 1,  5, 0,  1, 0, 0,  5, 1, 0);
        v(1, 1,  7, 0,  1, 0, 0,  7, 1, 0);   // up_reset while LOCKED
        v(0, 1,  1, 0,  1, 0, 0,  1, 1, 0);   // lock kept, no wrap
        v(0, 1,  3, 0,  1, 0, 0,  3, 1, 0);
        v(0, 1,  5, 1,  1, 0, 0,  5, 0, 0);   // clear while LOCKED and matching
        v(0, 1,  6, 1,  0, 0, 0,  7, 0, 0);   // clear with mismatch: no pulse
        v(0, 1,  9, 0,  0, 0, 0,  8, 0, 0);
        v(0, 1, 11, 0,  0, 0, 0, 11, 0, 0);
        v(0, 1, 13, 0,  0, 0, 0, 13, 0, 0);
        v(0, 1, 15, 0,  0, 0, 0, 15, 0, 0);
        v(0, 1,  1, 0,  1, 0, 0,  1, 0, 0);
        v(0, 1,  3, 0,  1, 0, 0,  3, 0, 0);

        repeat (3) @(posedge clock);
        #1;
        chk("rst_locked",   32'(locked),      32'd0);
        chk("rst_err_p",    32'(error_pulse), 32'd0);
        chk("rst_wrap_p",   32'(wrap_pulse),  32'd0);
        chk("rst_expected", 32'(expected),    32'd1);
        chk("rst_err_cnt",  32'(err_count),   32'd0);
        chk("rst_wrap_cnt", 32'(wrap_count),  32'd0);
        @(negedge clock);
        reset = 1'b1;

        foreach (vecs[i]) begin
            up_reset  = vecs[i].ur;
            up_enable = vecs[i].ue;
            count_in  = vecs[i].cin;
            clear     = vecs[i].clr;
            e.lk = vecs[i].lk; e.ep = vecs[i].ep; e.wp = vecs[i].wp;
            e.ex = vecs[i].ex; e.ec = vecs[i].ec; e.wc = vecs[i].wc;
            sb.push_back(e);
            @(posedge clock);
            #1;
            e = sb.pop_front();
            chk($sformatf("row%0d_locked", i),   32'(locked),      32'(e.lk));
            chk($sformatf("row%0d_err_p", i),    32'(error_pulse), 32'(e.ep));
            chk($sformatf("row%0d_wrap_p", i),   32'(wrap_pulse),  32'(e.wp));
            chk($sformatf("row%0d_expected", i), 32'(expected),    32'(e.ex));
            chk($sformatf("row%0d_err_cnt", i),  32'(err_count),   32'(e.ec));
            chk($sformatf("row%0d_wrap_cnt", i), 32'(wrap_count),  32'(e.wc));
        end
        clear = 1'b0;

        // Asynchronous reset between edges while LOCKED.
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("async_locked",   32'(locked),      32'd0);
        chk("async_err_p",    32'(error_pulse), 32'd0);
        chk("async_expected", 32'(expected),    32'd1);
        chk("async_err_cnt",  32'(err_count),   32'd0);
        repeat (2) @(posedge clock);
        #1;
        chk("async_hold_locked", 32'(locked), 32'd0);
        @(negedge clock);
        reset = 1'b1;

        // Narrow error counter: five faults saturate at 3.
        cnt2 = 4'd0;
        @(negedge clock);
        rst2 = 1'b1;
        for (int f = 1; f <= 5; f++) begin
            cyc2(1'b1, 1'b1, 1'b0);
            repeat (5) cyc2(1'b0, 1'b1, 1'b0);
            chk($sformatf("sat%0d_locked", f), 32'(locked2), 32'd1);
            cyc2(1'b0, 1'b1, 1'b1);
            want_ec = (f > 3) ? 3 : f;
            chk($sformatf("sat%0d_err_p", f),   32'(ep2),     32'd1);
            chk($sformatf("sat%0d_err_cnt", f), 32'(ec2),     32'(want_ec));
            chk($sformatf("sat%0d_fault", f),   32'(locked2), 32'd0);
        end
        @(negedge clock);
        rst2 = 1'b0;
        #1;
        chk("sat_async_err_cnt", 32'(ec2),     32'd0);
        chk("sat_async_locked",  32'(locked2), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
